mem16_seq: RTL and testbench
============================

# mem16_seq

Word/byte access sequencer between the eForth1 core's 16-bit memory port and the 8-bit single-port 128K SRAM (mb8_io bus). Accepts one request at a time and splits each 16-bit access into two byte cycles, big-endian: high byte at addr, low byte at addr+1. Absorbs the SRAM's 1-cycle read latency and returns assembled read data with a single-cycle ack.

## Interface
Parameters:
- ASZ, 17, byte address width (128K).
- DSZ, 16, core data width; only 16 is supported.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  request strobe; sampled only when rdy=1.
- wr  in  1  1=write, 0=read; qualified by req.
- bsel  in  1  1=byte access (C@/C!), 0=word access (@/!).
- addr  in  ASZ  byte address of the access.
- wdata  in  16  write data; byte writes use wdata[7:0].
- rdy  out  1  sequencer idle and able to accept a request.
- ack  out  1  one-cycle pulse on completion of any request.
- rdata  out  16  read result, valid while ack=1 and held until the next read completes; byte reads zero-extend.
- ai  out  ASZ  SRAM address (drives mb8_io.ai).
- vi  out  8  SRAM write data (drives mb8_io.vi).
- we  out  1  SRAM write enable (drives mb8_io.we).
- vo  in  8  SRAM read data, valid in the cycle after its address was presented with we=0.

## Operation
- The FSM has four states: IDLE, B0, B1, RD. rdy = (state==IDLE).
- Acceptance: at an edge where req & rdy, latch wr, bsel, addr and wdata, then go to B0. A req while rdy=0 is ignored and is not queued.
- B0: ai=addr. For writes, vi = bsel ? wdata[7:0] : wdata[15:8] and we=1. For reads, we=0.
- B1 (word accesses only): ai=addr+1, computed modulo 2^ASZ, so 17'h1ffff+1 wraps to 0. For writes, vi=wdata[7:0] and we=1. For a word read, B1 also captures vo into the high-byte register.
- RD (reads only): we=0, ai holds its last value. At exit, rdata is loaded with {hi,vo} for a word read or {8'h00,vo} for a byte read.
- Transitions:
  - Word read: IDLE→B0→B1→RD→IDLE.
  - Byte read: IDLE→B0→RD→IDLE.
  - Word write: IDLE→B0→B1→IDLE.
  - Byte write: IDLE→B0→IDLE.
- ack is registered. It is set on the edge that returns the FSM to IDLE, so ack and rdy=1 appear in the same cycle. A new req is accepted on that same cycle's closing edge.
- In IDLE: we=0, ai and vi hold their last values.
- Reset values: state=IDLE, rdy=1, ack=0, rdata=0, ai=0, vi=0, we=0, hi register=0.
- Reset mid-operation returns the FSM to IDLE immediately and drops we asynchronously. No ack is issued. A word write interrupted after B0 leaves only the high byte written; this is accepted behaviour.

## Timing
Let E0 be the accepting edge, and E1, E2, E3 the following edges.
- Byte write: SRAM writes at E1. ack is high in the cycle after E1. Occupancy is 2 cycles including the ack cycle.
- Word write: SRAM writes addr at E1 and addr+1 at E2. ack is high after E2.
- Byte read: SRAM reads addr at E1. vo is captured at E2. ack and rdata are valid after E2.
- Word read: high byte is captured at E2, low byte at E3. ack and rdata are valid after E3.
- Back-to-back requests: no idle bubble is required beyond the ack cycle. Peak word throughput is one word per 4 cycles for reads and one per 3 cycles for writes.
- ai, vi and we are combinational from state and the latched registers, and are glitch-free relative to clk.

## Structure
- mem16_pkg holds:
  - the state enum (IDLE, B0, B1, RD);
  - ASZ=17;
  - the BIG_ENDIAN=1 constant;
  - a typedef for the 17-bit byte address, shared with the core.
- Single module, no sub-modules. The top level wires ai/vi/we/vo to an mb8_io instance feeding spram8_128k.

## Test plan
- Word write 16'hA55A to addr 17'h00100, then word read of 17'h00100 → ack 3 cycles after acceptance, rdata=16'hA55A. A byte read of 17'h00101 → 16'h005A.
- Byte write 8'h3C to 17'h00101 over the previous word, then word read of 17'h00100 → 16'hA53C; the high byte is untouched.
- Word write 16'h1234 to 17'h1FFFF → byte read of 17'h1FFFF returns 16'h0012 and byte read of 17'h00000 returns 16'h0034 (wrap-around).
- Back-to-back: hold req=1 across 8 alternating word writes and reads at addr 2k, data 16'h0101*k → every read matches, rdy low exactly during B0/B1/RD, no request dropped or duplicated.
- req pulsed during B1 of a word read → ignored; exactly one ack; the FSM does not start a second access.
- rst asserted low during B1 of a word write → we=0 immediately, then rdy=1, ack=0, rdata=0. After release, a fresh word read completes normally.

Source files
------------

// File: rtl/mem16_pkg.sv
// rtl/mem16_pkg.sv - shared types and constants for the 16-bit to 8-bit memory sequencer
package mem16_pkg;

    localparam int ASZ = 17;
    localparam bit BIG_ENDIAN = 1'b1;

    typedef logic [ASZ-1:0] baddr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        RD   = 2'd3
    } state_t;

endpackage

// File: rtl/mem16_seq.sv
// rtl/mem16_seq.sv - splits 16-bit core accesses into two big-endian byte cycles on an 8-bit SRAM
module mem16_seq #(
    parameter int ASZ = 17,
    parameter int DSZ = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           wr,
    input  logic           bsel,
    input  logic [ASZ-1:0] addr,
    input  logic [DSZ-1:0] wdata,
    output logic           rdy,
    output logic           ack,
    output logic [DSZ-1:0] rdata,
    output logic [ASZ-1:0] ai,
    output logic [7:0]     vi,
    output logic           we,
    input  logic [7:0]     vo
);
    import mem16_pkg::*;

    state_t         state, state_n;
    logic           wr_q, bsel_q, ack_q;
    logic [ASZ-1:0] addr_q, ai_q;
    logic [DSZ-1:0] wdata_q, rdata_q;
    logic [7:0]     vi_q, hi_q;
    logic [7:0]     first_byte, second_byte;

    assign first_byte  = BIG_ENDIAN ? wdata_q[15:8] : wdata_q[7:0];
    assign second_byte = BIG_ENDIAN ? wdata_q[7:0]  : wdata_q[15:8];

    assign rdy   = (state == IDLE);
    assign ack   = ack_q;
    assign rdata = rdata_q;

    // ai/vi hold their previous values outside B0/B1, so they come from the *_q copies
    always_comb begin
        state_n = state;
        ai      = ai_q;
        vi      = vi_q;
        we      = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_n = B0;
            end
            B0: begin
                ai = addr_q;
                if (wr_q) begin
                    we = 1'b1;
                    vi = bsel_q ? wdata_q[7:0] : first_byte;
                end
                if (!bsel_q)   state_n = B1;
                else if (wr_q) state_n = IDLE;
                else           state_n = RD;
            end
            B1: begin
                ai = addr_q + {{(ASZ-1){1'b0}}, 1'b1};
                if (wr_q) begin
                    we = 1'b1;
                    vi = second_byte;
                end
                state_n = wr_q ? IDLE : RD;
            end
            RD: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            bsel_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ai_q    <= '0;
            vi_q    <= '0;
            hi_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state <= state_n;
            ai_q  <= ai;
            vi_q  <= vi;
            ack_q <= (state != IDLE) && (state_n == IDLE);
            if (state == IDLE && req) begin
                wr_q    <= wr;
                bsel_q  <= bsel;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            // vo in B1 is the SRAM's answer to the B0 address
            if (state == B1 && !wr_q) hi_q <= vo;
            if (state == RD) rdata_q <= bsel_q ? {8'h00, vo} : {hi_q, vo};
        end
    end

endmodule

// File: tb/tb_mem16_seq.sv
// tb/tb_mem16_seq.sv - self-checking bench for mem16_seq with a byte-array SRAM and reference model
module tb_mem16_seq;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic        bsel;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic        rdy;
    logic        ack;
    logic [15:0] rdata;
    logic [16:0] ai;
    logic [7:0]  vi;
    logic        we;
    logic [7:0]  vo;

    int tests_run;
    int tests_failed;

    logic [7:0] sram    [0:131071];
    logic [7:0] ref_mem [0:131071];

    mem16_seq #(.ASZ(17), .DSZ(16)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .bsel(bsel), .addr(addr),
        .wdata(wdata), .rdy(rdy), .ack(ack), .rdata(rdata),
        .ai(ai), .vi(vi), .we(we), .vo(vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port SRAM: synchronous write, read data registered one cycle after the address
    always @(posedge clk) begin
        if (we) sram[ai] <= vi;
        vo <= sram[ai];
    end

    task automatic ref_apply(input logic w, input logic b, input logic [16:0] a, input logic [15:0] d);
        logic [16:0] a1;
        a1 = a + 17'd1;
        if (w) begin
            if (b) ref_mem[a] = d[7:0];
            else begin
                ref_mem[a]  = d[15:8];
                ref_mem[a1] = d[7:0];
            end
        end
    endtask

    function automatic logic [15:0] ref_read(input logic b, input logic [16:0] a);
        logic [16:0] a1;
        a1 = a + 17'd1;
        return b ? {8'h00, ref_mem[a]} : {ref_mem[a], ref_mem[a1]};
    endfunction

    function automatic int exp_lat(input logic w, input logic b);
        return (b ? 1 : 2) + (w ? 0 : 1);
    endfunction

    task automatic run_op(input logic w, input logic b, input logic [16:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd);
        wr = w; bsel = b; addr = a; wdata = d; req = 1'b1;
        ref_apply(w, b, a, d);
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        while (ack !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata;
    endtask

    task automatic test_reset;
        rst = 1'b0; req = 1'b0; wr = 1'b0; bsel = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({rdy, ack, we} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_ctl: rdy/ack/we=%b expected 100", {rdy, ack, we});
        end
        tests_run++;
        if (rdata !== 16'h0 || ai !== 17'h0 || vi !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata=%h ai=%h vi=%h expected zeros", rdata, ai, vi);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw;
        int lat;
        logic [15:0] rd;
        run_op(1'b1, 1'b0, 17'h00100, 16'hA55A, lat, rd);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("FAIL word_write_lat: got %0d expected 2", lat); end
        run_op(1'b0, 1'b0, 17'h00100, 16'h0, lat, rd);
        tests_run++;
        if (lat !== 3) begin tests_failed++; $display("FAIL word_read_lat: got %0d expected 3", lat); end
        tests_run++;
        if (rd !== 16'hA55A) begin tests_failed++; $display("FAIL word_read_data: got %h expected a55a", rd); end
        run_op(1'b0, 1'b1, 17'h00101, 16'h0, lat, rd);
        tests_run++;
        if (lat !== 2 || rd !== 16'h005A) begin
            tests_failed++;
            $display("FAIL byte_read: lat=%0d data=%h expected 2 005a", lat, rd);
        end
    endtask

    task automatic test_byte_overwrite;
        int lat;
        logic [15:0] rd;
        run_op(1'b1, 1'b1, 17'h00101, 16'hFF3C, lat, rd);
        tests_run++;
        if (lat !== 1) begin tests_failed++; $display("FAIL byte_write_lat: got %0d expected 1", lat); end
        run_op(1'b0, 1'b0, 17'h00100, 16'h0, lat, rd);
        tests_run++;
        if (rd !== 16'hA53C) begin tests_failed++; $display("FAIL byte_overwrite: got %h expected a53c", rd); end
    endtask

    task automatic test_wrap;
        int lat;
        logic [15:0] rd;
        run_op(1'b1, 1'b0, 17'h1FFFF, 16'h1234, lat, rd);
        run_op(1'b0, 1'b1, 17'h1FFFF, 16'h0, lat, rd);
        tests_run++;
        if (rd !== 16'h0012) begin tests_failed++; $display("FAIL wrap_hi: got %h expected 0012", rd); end
        run_op(1'b0, 1'b1, 17'h00000, 16'h0, lat, rd);
        tests_run++;
        if (rd !== 16'h0034) begin tests_failed++; $display("FAIL wrap_lo: got %h expected 0034", rd); end
    endtask

    task automatic test_back_to_back;
        int i, k, edges, acks, rdy_bad, rd_bad;
        logic [15:0] e;
        i = 0; edges = 0; acks = 0; rdy_bad = 0; rd_bad = 0;
        wr = 1'b1; bsel = 1'b0; addr = 17'd0; wdata = 16'h0000; req = 1'b1;
        ref_apply(1'b1, 1'b0, 17'd0, 16'h0000);
        @(posedge clk); #1;
        edges = 1;
        while (acks < 16 && edges < 100) begin
            if (rdy !== ack) rdy_bad++;
            if (ack === 1'b1) begin
                if (i % 2 == 1) begin
                    k = i / 2;
                    e = ref_read(1'b0, 17'(2 * k));
                    if (rdata !== e || rdata !== 16'(16'h0101 * k)) rd_bad++;
                end
                acks++;
                i++;
                if (i < 16) begin
                    k = i / 2;
                    wr = (i % 2 == 0); bsel = 1'b0; addr = 17'(2 * k); wdata = 16'(16'h0101 * k);
                    ref_apply(wr, 1'b0, addr, wdata);
                end else begin
                    req = 1'b0;
                end
            end
            if (acks < 16) begin
                @(posedge clk); #1;
                edges++;
            end
        end
        req = 1'b0;
        tests_run++;
        if (acks !== 16) begin tests_failed++; $display("FAIL b2b_acks: got %0d expected 16", acks); end
        tests_run++;
        if (edges !== 56) begin tests_failed++; $display("FAIL b2b_cycles: got %0d expected 56", edges); end
        tests_run++;
        if (rdy_bad !== 0) begin tests_failed++; $display("FAIL b2b_rdy: %0d cycles with rdy!=ack expected 0", rdy_bad); end
        tests_run++;
        if (rd_bad !== 0) begin tests_failed++; $display("FAIL b2b_rdata: %0d bad reads expected 0", rd_bad); end
    endtask

    task automatic test_req_ignored;
        int lat, acks;
        logic [15:0] rd, got;
        run_op(1'b1, 1'b0, 17'h00200, 16'h5AA5, lat, rd);
        wr = 1'b0; bsel = 1'b0; addr = 17'h00100; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        wr = 1'b1; addr = 17'h00200; wdata = 16'hFFFF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        acks = 0; got = 16'h0;
        for (int c = 0; c < 10; c++) begin
            if (ack === 1'b1) begin acks++; got = rdata; end
            @(posedge clk); #1;
        end
        tests_run++;
        if (acks !== 1) begin tests_failed++; $display("FAIL ignored_req_acks: got %0d expected 1", acks); end
        tests_run++;
        if (got !== ref_read(1'b0, 17'h00100)) begin
            tests_failed++;
            $display("FAIL ignored_req_data: got %h expected %h", got, ref_read(1'b0, 17'h00100));
        end
        run_op(1'b0, 1'b0, 17'h00200, 16'h0, lat, rd);
        tests_run++;
        if (rd !== 16'h5AA5) begin tests_failed++; $display("FAIL ignored_req_nowrite: got %h expected 5aa5", rd); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [15:0] rd;
        run_op(1'b1, 1'b0, 17'h00300, 16'h1122, lat, rd);
        wr = 1'b1; bsel = 1'b0; addr = 17'h00300; wdata = 16'hBEEF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (we !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_we_b1: got %b expected 1", we); end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({we, rdy, ack} !== 3'b010) begin
            tests_failed++;
            $display("FAIL rst_mid_ctl: we/rdy/ack=%b expected 010", {we, rdy, ack});
        end
        tests_run++;
        if (rdata !== 16'h0 || ai !== 17'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_data: rdata=%h ai=%h expected 0 0", rdata, ai);
        end
        #3 rst = 1'b1;
        ref_mem[17'h00300] = 8'hBE;
        @(posedge clk); #1;
        tests_run++;
        if (ack !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_noack: got %b expected 0", ack); end
        run_op(1'b0, 1'b0, 17'h00300, 16'h0, lat, rd);
        tests_run++;
        if (lat !== 3 || rd !== 16'hBE22) begin
            tests_failed++;
            $display("FAIL rst_mid_read: lat=%0d data=%h expected 3 be22", lat, rd);
        end
    endtask

    task automatic test_random;
        int lat, lat_bad, rd_bad;
        logic [15:0] rd, e;
        logic [16:0] a;
        logic w, b;
        lat_bad = 0; rd_bad = 0;
        for (int j = 0; j < 16; j += 2)
            run_op(1'b1, 1'b0, 17'h1FFF8 + 17'(j), 16'($urandom), lat, rd);
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom);
            b = 1'($urandom);
            a = 17'h1FFF8 + 17'($urandom_range(0, 14));
            e = ref_read(b, a);
            run_op(w, b, a, 16'($urandom), lat, rd);
            if (lat != exp_lat(w, b)) lat_bad++;
            if (!w && rd !== e) rd_bad++;
        end
        tests_run++;
        if (lat_bad !== 0) begin tests_failed++; $display("FAIL random_lat: %0d bad latencies expected 0", lat_bad); end
        tests_run++;
        if (rd_bad !== 0) begin tests_failed++; $display("FAIL random_rdata: %0d bad reads expected 0", rd_bad); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_word_rw();
        test_byte_overwrite();
        test_wrap();
        test_back_to_back();
        test_req_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
